// File: rtl/dcache_controller_pkg.sv
// Shared constants and FSM state type for the write-back data cache controller.
package dcache_controller_pkg;

  localparam int unsigned DC_ADDR_WIDTH  = 32;
  localparam int unsigned DC_DATA_WIDTH  = 32;
  localparam int unsigned DC_SB_WIDTH    = 64;
  localparam int unsigned DC_NLINES      = 4;
  localparam int unsigned DC_LINE_WORDS  = 4;
  localparam int unsigned DC_LINE_WIDTH  = DC_LINE_WORDS * DC_DATA_WIDTH;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWb   = 2'd1,
    StFill = 2'd2
  } dc_state_e;

endpackage

// File: rtl/dcache_controller_if.sv
// Load lookup, store-buffer drain and main-memory line bus of the data cache.
interface dcache_controller_if #(
  parameter int unsigned ADDR_WIDTH = dcache_controller_pkg::DC_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = dcache_controller_pkg::DC_DATA_WIDTH,
  parameter int unsigned SB_WIDTH   = dcache_controller_pkg::DC_SB_WIDTH,
  parameter int unsigned LINE_WIDTH = dcache_controller_pkg::DC_LINE_WIDTH
) ();

  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_hit;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  sb_valid;
  logic [SB_WIDTH-1:0]   sb_entry;
  logic                  sb_ready;
  logic                  stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  ld_valid, ld_addr, sb_valid, sb_entry, mem_rdata, mem_ack,
    output ld_hit, ld_data, sb_ready, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ld_valid, ld_addr, sb_valid, sb_entry, mem_rdata, mem_ack,
    input  ld_hit, ld_data, sb_ready, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage: two async read ports, one sync write port and a dirty clear.
module dcache_line_array #(
  parameter int unsigned NLINES     = 4,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_W      = 26
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [$clog2(NLINES)-1:0]        rd_a_idx_i,
  output logic                             rd_a_valid_o,
  output logic                             rd_a_dirty_o,
  output logic [TAG_W-1:0]                 rd_a_tag_o,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] rd_a_line_o,
  input  logic [$clog2(NLINES)-1:0]        rd_b_idx_i,
  output logic                             rd_b_valid_o,
  output logic                             rd_b_dirty_o,
  output logic [TAG_W-1:0]                 rd_b_tag_o,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] rd_b_line_o,
  input  logic                             wr_en_i,
  input  logic                             wr_full_i,
  input  logic [$clog2(NLINES)-1:0]        wr_idx_i,
  input  logic [TAG_W-1:0]                 wr_tag_i,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] wr_line_i,
  input  logic                             wr_dirty_i,
  input  logic [$clog2(LINE_WORDS)-1:0]    wr_off_i,
  input  logic [DATA_WIDTH-1:0]            wr_word_i,
  input  logic                             clr_en_i,
  input  logic [$clog2(NLINES)-1:0]        clr_idx_i
);

  localparam int unsigned LineW = LINE_WORDS * DATA_WIDTH;

  logic [NLINES-1:0] valid_q;
  logic [NLINES-1:0] dirty_q;
  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [LineW-1:0]  data_q [NLINES];

  assign rd_a_valid_o = valid_q[rd_a_idx_i];
  assign rd_a_dirty_o = dirty_q[rd_a_idx_i];
  assign rd_a_tag_o   = tag_q[rd_a_idx_i];
  assign rd_a_line_o  = data_q[rd_a_idx_i];
  assign rd_b_valid_o = valid_q[rd_b_idx_i];
  assign rd_b_dirty_o = dirty_q[rd_b_idx_i];
  assign rd_b_tag_o   = tag_q[rd_b_idx_i];
  assign rd_b_line_o  = data_q[rd_b_idx_i];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_en_i) begin
        if (wr_full_i) begin
          valid_q[wr_idx_i] <= 1'b1;
          dirty_q[wr_idx_i] <= wr_dirty_i;
        end else begin
          dirty_q[wr_idx_i] <= 1'b1;
        end
      end
      if (clr_en_i) begin
        dirty_q[clr_idx_i] <= 1'b0;
      end
    end
  end

  // Tag and data need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (!reset && wr_en_i) begin
      if (wr_full_i) begin
        tag_q[wr_idx_i]  <= wr_tag_i;
        data_q[wr_idx_i] <= wr_line_i;
      end else begin
        data_q[wr_idx_i][wr_off_i*DATA_WIDTH +: DATA_WIDTH] <= wr_word_i;
      end
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller behind the store buffer.
module dcache_controller
  import dcache_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DC_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DC_DATA_WIDTH,
  parameter int unsigned SB_WIDTH   = DC_SB_WIDTH,
  parameter int unsigned NLINES     = DC_NLINES,
  parameter int unsigned LINE_WORDS = DC_LINE_WORDS
) (
  input logic                clk,
  input logic                reset,
  dcache_controller_if.slave bus
);

  localparam int unsigned LineW  = LINE_WORDS * DATA_WIDTH;
  localparam int unsigned WoffLsb = $clog2(DATA_WIDTH / 8);
  localparam int unsigned WoffW  = $clog2(LINE_WORDS);
  localparam int unsigned IdxLsb = WoffLsb + WoffW;
  localparam int unsigned IdxW   = $clog2(NLINES);
  localparam int unsigned TagLsb = IdxLsb + IdxW;
  localparam int unsigned TagW   = ADDR_WIDTH - TagLsb;

  logic [ADDR_WIDTH-1:0] sb_addr;
  logic [DATA_WIDTH-1:0] sb_data;
  logic [IdxW-1:0]       ld_idx, sb_idx, pend_idx, miss_idx;
  logic [TagW-1:0]       ld_tag, sb_tag, pend_tag;
  logic [WoffW-1:0]      ld_off, sb_off, pend_off;

  assign sb_addr  = bus.sb_entry[SB_WIDTH-1 -: ADDR_WIDTH];
  assign sb_data  = bus.sb_entry[DATA_WIDTH-1:0];
  assign ld_idx   = bus.ld_addr[IdxLsb +: IdxW];
  assign ld_tag   = bus.ld_addr[TagLsb +: TagW];
  assign ld_off   = bus.ld_addr[WoffLsb +: WoffW];
  assign sb_idx   = sb_addr[IdxLsb +: IdxW];
  assign sb_tag   = sb_addr[TagLsb +: TagW];
  assign sb_off   = sb_addr[WoffLsb +: WoffW];

  logic             a_valid, a_dirty, b_valid, b_dirty;
  logic [TagW-1:0]  a_tag, b_tag;
  logic [LineW-1:0] a_line, b_line;

  logic             wr_en, wr_full, wr_dirty, clr_en;
  logic [IdxW-1:0]  wr_idx;
  logic [TagW-1:0]  wr_tag;
  logic [LineW-1:0] wr_line;
  logic [WoffW-1:0] wr_off;
  logic [DATA_WIDTH-1:0] wr_word;

  dc_state_e             state_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic [DATA_WIDTH-1:0] pend_data_q;
  logic                  pend_store_q;
  logic                  stall_q, mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [LineW-1:0]      mem_wdata_q;

  assign pend_idx = pend_addr_q[IdxLsb +: IdxW];
  assign pend_tag = pend_addr_q[TagLsb +: TagW];
  assign pend_off = pend_addr_q[WoffLsb +: WoffW];

  dcache_line_array #(
    .NLINES     (NLINES),
    .LINE_WORDS (LINE_WORDS),
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_W      (TagW)
  ) u_array (
    .clk          (clk),
    .reset        (reset),
    .rd_a_idx_i   (ld_idx),
    .rd_a_valid_o (a_valid),
    .rd_a_dirty_o (a_dirty),
    .rd_a_tag_o   (a_tag),
    .rd_a_line_o  (a_line),
    .rd_b_idx_i   (sb_idx),
    .rd_b_valid_o (b_valid),
    .rd_b_dirty_o (b_dirty),
    .rd_b_tag_o   (b_tag),
    .rd_b_line_o  (b_line),
    .wr_en_i      (wr_en),
    .wr_full_i    (wr_full),
    .wr_idx_i     (wr_idx),
    .wr_tag_i     (wr_tag),
    .wr_line_i    (wr_line),
    .wr_dirty_i   (wr_dirty),
    .wr_off_i     (wr_off),
    .wr_word_i    (wr_word),
    .clr_en_i     (clr_en),
    .clr_idx_i    (pend_idx)
  );

  logic ld_hit, sb_hit, idle, ld_miss, sb_ready, st_hit, st_miss, fill_done;
  logic vic_valid, vic_dirty;
  logic [TagW-1:0]       vic_tag;
  logic [LineW-1:0]      vic_line;
  logic [ADDR_WIDTH-1:0] miss_addr;

  assign ld_hit    = a_valid && (a_tag == ld_tag);
  assign sb_hit    = b_valid && (b_tag == sb_tag);
  assign idle      = (state_q == StIdle);
  assign ld_miss   = idle && bus.ld_valid && !ld_hit;
  // A load in the same cycle always wins over the store drain.
  assign sb_ready  = !reset && idle && !bus.ld_valid;
  assign st_hit    = bus.sb_valid && sb_ready && sb_hit;
  assign st_miss   = bus.sb_valid && sb_ready && !sb_hit;
  assign fill_done = (state_q == StFill) && bus.mem_ack;
  assign clr_en    = (state_q == StWb) && bus.mem_ack;

  assign miss_addr = ld_miss ? bus.ld_addr : sb_addr;
  assign miss_idx  = ld_miss ? ld_idx  : sb_idx;
  assign vic_valid = ld_miss ? a_valid : b_valid;
  assign vic_dirty = ld_miss ? a_dirty : b_dirty;
  assign vic_tag   = ld_miss ? a_tag   : b_tag;
  assign vic_line  = ld_miss ? a_line  : b_line;

  always_comb begin
    wr_en    = 1'b0;
    wr_full  = 1'b0;
    wr_idx   = sb_idx;
    wr_tag   = pend_tag;
    wr_line  = bus.mem_rdata;
    wr_dirty = pend_store_q;
    wr_off   = sb_off;
    wr_word  = sb_data;
    if (st_hit) begin
      wr_en = 1'b1;
    end else if (fill_done) begin
      wr_en   = 1'b1;
      wr_full = 1'b1;
      wr_idx  = pend_idx;
      // A pending store overwrites its word of the incoming line in the same write.
      if (pend_store_q) begin
        wr_line[pend_off*DATA_WIDTH +: DATA_WIDTH] = pend_data_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      pend_store_q <= 1'b0;
      stall_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ld_miss || st_miss) begin
            pend_addr_q  <= miss_addr;
            pend_data_q  <= sb_data;
            pend_store_q <= st_miss;
            stall_q      <= 1'b1;
            mem_req_q    <= 1'b1;
            if (vic_valid && vic_dirty) begin
              state_q     <= StWb;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {vic_tag, miss_idx, {IdxLsb{1'b0}}};
              mem_wdata_q <= vic_line;
            end else begin
              state_q    <= StFill;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {miss_addr[ADDR_WIDTH-1:IdxLsb], {IdxLsb{1'b0}}};
            end
          end
        end
        StWb: begin
          if (bus.mem_ack) begin
            state_q    <= StFill;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {pend_addr_q[ADDR_WIDTH-1:IdxLsb], {IdxLsb{1'b0}}};
          end
        end
        StFill: begin
          if (bus.mem_ack) begin
            state_q   <= StIdle;
            stall_q   <= 1'b0;
            mem_req_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ld_hit    = ld_hit;
  assign bus.ld_data   = ld_hit ? a_line[ld_off*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.sb_ready  = sb_ready;
  assign bus.stall     = stall_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  logic unused_byte_bits;
  assign unused_byte_bits = ^{bus.ld_addr[WoffLsb-1:0], sb_addr[WoffLsb-1:0],
                              pend_addr_q[WoffLsb-1:0]};

endmodule
